// File: rtl/reservation_station_mcdb.sv
// Reservation station with NUM_CDB wakeup buses, oldest-ready selection by age matrix,
// a single registered issue slot with valid/ready handshake, and synchronous flush.
module reservation_station_mcdb #(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned NUM_CDB     = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned TAG_W       = 5,
  parameter int unsigned FUNC_W      = 5,
  localparam int unsigned CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  logic [FUNC_W-1:0]          dispatch_func,
  input  logic [TAG_W-1:0]           dispatch_t1,
  input  logic [TAG_W-1:0]           dispatch_t2,
  input  logic                       dispatch_rdy1,
  input  logic                       dispatch_rdy2,
  input  logic [XLEN-1:0]            dispatch_v1,
  input  logic [XLEN-1:0]            dispatch_v2,
  input  logic [TAG_W-1:0]           dispatch_dst,
  input  logic [XLEN-1:0]            dispatch_pc,
  input  logic [XLEN-1:0]            dispatch_imm,
  input  logic [NUM_CDB-1:0]         cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0]    cdb_value,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [FUNC_W-1:0]          issue_func,
  output logic [TAG_W-1:0]           issue_dst,
  output logic [XLEN-1:0]            issue_v1,
  output logic [XLEN-1:0]            issue_v2,
  output logic [XLEN-1:0]            issue_pc,
  output logic [XLEN-1:0]            issue_imm,
  output logic [CNT_W-1:0]           free_count
);

  localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  t1;
    logic [TAG_W-1:0]  t2;
    logic              r1;
    logic              r2;
    logic [XLEN-1:0]   v1;
    logic [XLEN-1:0]   v2;
    logic [TAG_W-1:0]  dst;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
  } entry_t;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  dst;
    logic [XLEN-1:0]   v1;
    logic [XLEN-1:0]   v2;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
  } issue_t;

  entry_t                 ent_q   [NUM_ENTRIES];
  entry_t                 ent_d   [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  // older_q[i][j] set means entry i was dispatched before entry j
  logic [NUM_ENTRIES-1:0] older_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] older_d [NUM_ENTRIES];
  issue_t                 iss_q, iss_d;
  logic                   iv_q, iv_d;

  logic [CNT_W-1:0]       free_cnt;
  logic [IDX_W-1:0]       free_idx;
  logic [NUM_ENTRIES-1:0] elig, blk, sel;
  logic [IDX_W-1:0]       sel_idx;
  logic                   accept, load;
  logic [XLEN:0]          dlk1, dlk2;
  logic [XLEN:0]          wk1 [NUM_ENTRIES];
  logic [XLEN:0]          wk2 [NUM_ENTRIES];
  entry_t                 new_ent;

  // {hit, value}; lowest channel wins when several broadcast the same tag
  function automatic logic [XLEN:0] cdb_lookup(input logic [TAG_W-1:0] tag);
    logic [XLEN:0] res;
    res = '0;
    for (int k = NUM_CDB - 1; k >= 0; k--) begin
      if (cdb_valid[k] && (cdb_tag[k*TAG_W +: TAG_W] == tag)) begin
        res = {1'b1, cdb_value[k*XLEN +: XLEN]};
      end
    end
    return res;
  endfunction

  always_comb begin : free_scan
    free_cnt = '0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        free_cnt = free_cnt + CNT_W'(1);
        free_idx = IDX_W'(i);
      end
    end
  end

  assign free_count     = free_cnt;
  assign dispatch_ready = (free_cnt != '0) && !flush;
  assign accept         = dispatch_valid && dispatch_ready;

  always_comb begin : select
    blk     = '0;
    sel_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      elig[i] = valid_q[i] & ent_q[i].r1 & ent_q[i].r2;
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (j != i && elig[j] && older_q[j][i]) blk[i] = 1'b1;
      end
    end
    sel = elig & ~blk;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (sel[i]) sel_idx = IDX_W'(i);
    end
  end

  assign load = !flush && (!iv_q || issue_ready) && (|elig);

  always_comb begin : lookups
    dlk1 = cdb_lookup(dispatch_t1);
    dlk2 = cdb_lookup(dispatch_t2);
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wk1[i] = cdb_lookup(ent_q[i].t1);
      wk2[i] = cdb_lookup(ent_q[i].t2);
    end
  end

  always_comb begin : new_entry
    new_ent      = '0;
    new_ent.func = dispatch_func;
    new_ent.t1   = dispatch_t1;
    new_ent.t2   = dispatch_t2;
    new_ent.dst  = dispatch_dst;
    new_ent.pc   = dispatch_pc;
    new_ent.imm  = dispatch_imm;
    new_ent.r1   = dispatch_rdy1 | dlk1[XLEN];
    new_ent.r2   = dispatch_rdy2 | dlk2[XLEN];
    new_ent.v1   = dispatch_rdy1 ? dispatch_v1 : dlk1[XLEN-1:0];
    new_ent.v2   = dispatch_rdy2 ? dispatch_v2 : dlk2[XLEN-1:0];
  end

  // entry array next state: wakeup, issue removal, dispatch insert, flush
  always_comb begin : entry_next
    valid_d = valid_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      ent_d[i]   = ent_q[i];
      older_d[i] = older_q[i];
      if (valid_q[i] && !ent_q[i].r1 && wk1[i][XLEN]) begin
        ent_d[i].r1 = 1'b1;
        ent_d[i].v1 = wk1[i][XLEN-1:0];
      end
      if (valid_q[i] && !ent_q[i].r2 && wk2[i][XLEN]) begin
        ent_d[i].r2 = 1'b1;
        ent_d[i].v2 = wk2[i][XLEN-1:0];
      end
    end
    if (load) valid_d[sel_idx] = 1'b0;
    if (accept) begin
      ent_d[free_idx]   = new_ent;
      valid_d[free_idx] = 1'b1;
      older_d[free_idx] = '0;
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (IDX_W'(j) != free_idx) older_d[j][free_idx] = 1'b1;
      end
    end
    if (flush) valid_d = '0;
  end

  always_comb begin : issue_next
    iss_d = iss_q;
    iv_d  = iv_q;
    if (flush) begin
      iv_d = 1'b0;
    end else if (!iv_q || issue_ready) begin
      iv_d = |elig;
      if (|elig) begin
        iss_d.func = ent_q[sel_idx].func;
        iss_d.dst  = ent_q[sel_idx].dst;
        iss_d.v1   = ent_q[sel_idx].v1;
        iss_d.v2   = ent_q[sel_idx].v2;
        iss_d.pc   = ent_q[sel_idx].pc;
        iss_d.imm  = ent_q[sel_idx].imm;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      iv_q    <= 1'b0;
      iss_q   <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i]   <= '0;
        older_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      iv_q    <= iv_d;
      iss_q   <= iss_d;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_q[i]   <= ent_d[i];
        older_q[i] <= older_d[i];
      end
    end
  end

  assign issue_valid = iv_q;
  assign issue_func  = iss_q.func;
  assign issue_dst   = iss_q.dst;
  assign issue_v1    = iss_q.v1;
  assign issue_v2    = iss_q.v2;
  assign issue_pc    = iss_q.pc;
  assign issue_imm   = iss_q.imm;

endmodule

// File: tb/tb_reservation_station_mcdb.sv
// Directed bench for reservation_station_mcdb: vector table plus stall, flush and reset sequences.
module tb_reservation_station_mcdb;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        dispatch_valid, dispatch_ready;
  logic [4:0]  dispatch_func, dispatch_t1, dispatch_t2, dispatch_dst;
  logic        dispatch_rdy1, dispatch_rdy2;
  logic [31:0] dispatch_v1, dispatch_v2, dispatch_pc, dispatch_imm;
  logic [1:0]  cdb_valid;
  logic [9:0]  cdb_tag;
  logic [63:0] cdb_value;
  logic        issue_valid, issue_ready;
  logic [4:0]  issue_func, issue_dst;
  logic [31:0] issue_v1, issue_v2, issue_pc, issue_imm;
  logic [3:0]  free_count;

  int checks = 0;
  int errors = 0;

  reservation_station_mcdb dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_func(dispatch_func), .dispatch_t1(dispatch_t1), .dispatch_t2(dispatch_t2),
    .dispatch_rdy1(dispatch_rdy1), .dispatch_rdy2(dispatch_rdy2),
    .dispatch_v1(dispatch_v1), .dispatch_v2(dispatch_v2), .dispatch_dst(dispatch_dst),
    .dispatch_pc(dispatch_pc), .dispatch_imm(dispatch_imm),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_func(issue_func), .issue_dst(issue_dst), .issue_v1(issue_v1), .issue_v2(issue_v2),
    .issue_pc(issue_pc), .issue_imm(issue_imm), .free_count(free_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  t1, t2, dst;
    logic        r1, r2;
    logic [31:0] v1, v2;
    logic [1:0]  cv;
    logic [4:0]  ct0, ct1;
    logic [31:0] cx0, cx1;
    logic        ev;
    logic [4:0]  edst;
    logic [31:0] ev1, ev2;
    logic [3:0]  efree;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic dv, input logic [4:0] t1, input logic r1,
                              input logic [31:0] v1, input logic [4:0] t2, input logic r2,
                              input logic [31:0] v2, input logic [4:0] dst, input logic [1:0] cv,
                              input logic [4:0] ct0, input logic [31:0] cx0,
                              input logic [4:0] ct1, input logic [31:0] cx1,
                              input logic ev, input logic [4:0] edst, input logic [31:0] ev1,
                              input logic [31:0] ev2, input logic [3:0] efree);
    vec_t v;
    v.dv = dv; v.t1 = t1; v.r1 = r1; v.v1 = v1; v.t2 = t2; v.r2 = r2; v.v2 = v2; v.dst = dst;
    v.cv = cv; v.ct0 = ct0; v.cx0 = cx0; v.ct1 = ct1; v.cx1 = cx1;
    v.ev = ev; v.edst = edst; v.ev1 = ev1; v.ev2 = ev2; v.efree = efree;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    dispatch_valid = 1'b0; dispatch_func = '0; dispatch_t1 = '0; dispatch_t2 = '0;
    dispatch_rdy1 = 1'b0; dispatch_rdy2 = 1'b0; dispatch_v1 = '0; dispatch_v2 = '0;
    dispatch_dst = '0; dispatch_pc = '0; dispatch_imm = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0;
  endtask

  // func/pc/imm derived from dst so issued sideband can be checked against dst alone
  task automatic set_disp(input logic [4:0] t1, input logic r1, input logic [31:0] v1,
                          input logic [4:0] t2, input logic r2, input logic [31:0] v2,
                          input logic [4:0] dst);
    dispatch_valid = 1'b1; dispatch_t1 = t1; dispatch_rdy1 = r1; dispatch_v1 = v1;
    dispatch_t2 = t2; dispatch_rdy2 = r2; dispatch_v2 = v2; dispatch_dst = dst;
    dispatch_func = dst + 5'd1; dispatch_pc = 32'h1000 + 32'(dst); dispatch_imm = 32'h2000 + 32'(dst);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_issue(input string name, input logic [4:0] dst, input logic [31:0] v1,
                           input logic [31:0] v2);
    chk({name, "_valid"}, 32'(issue_valid), 32'd1);
    chk({name, "_dst"}, 32'(issue_dst), 32'(dst));
    chk({name, "_v1"}, issue_v1, v1);
    chk({name, "_v2"}, issue_v2, v2);
    chk({name, "_func"}, 32'(issue_func), 32'(dst + 5'd1));
    chk({name, "_pc"}, issue_pc, 32'h1000 + 32'(dst));
    chk({name, "_imm"}, issue_imm, 32'h2000 + 32'(dst));
  endtask

  initial begin
    //           dv t1 r1 v1     t2 r2 v2     dst  cv    ct0 cx0    ct1 cx1    ev edst ev1    ev2    free
    vecs[0]  = mk(1, 0, 1, 5,     0, 1, 7,     3,   2'b00, 0, 0,     0, 0,     0, 0,   0,     0,     7);
    vecs[1]  = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     1, 3,   5,     7,     8);
    vecs[2]  = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     0, 0,   0,     0,     8);
    vecs[3]  = mk(1, 9, 0, 0,     0, 1, 2,     10,  2'b00, 0, 0,     0, 0,     0, 0,   0,     0,     7);
    vecs[4]  = mk(1, 0, 1, 32'h11,0, 1, 32'h22,11,  2'b00, 0, 0,     0, 0,     0, 0,   0,     0,     6);
    vecs[5]  = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b01, 9, 32'h55,0, 0,     1, 11,  32'h11,32'h22,7);
    vecs[6]  = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     1, 10,  32'h55,2,     8);
    vecs[7]  = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     0, 0,   0,     0,     8);
    vecs[8]  = mk(1, 0, 1, 1,     4, 0, 0,     12,  2'b10, 0, 0,     4, 32'hAB,0, 0,   0,     0,     7);
    vecs[9]  = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     1, 12,  1,     32'hAB,8);
    vecs[10] = mk(1, 0, 1, 2,     8, 0, 0,     13,  2'b11, 8, 32'hC0,8, 32'hC1,0, 0,   0,     0,     7);
    vecs[11] = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     1, 13,  2,     32'hC0,8);
    vecs[12] = mk(1, 6, 0, 0,     7, 1, 3,     14,  2'b00, 0, 0,     0, 0,     0, 0,   0,     0,     7);
    vecs[13] = mk(1, 6, 1, 4,     7, 0, 0,     15,  2'b00, 0, 0,     0, 0,     0, 0,   0,     0,     6);
    vecs[14] = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b11, 7, 32'h77,6, 32'h66,0, 0,   0,     0,     6);
    vecs[15] = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     1, 14,  32'h66,3,     7);
    vecs[16] = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     1, 15,  4,     32'h77,8);
    vecs[17] = mk(0, 0, 0, 0,     0, 0, 0,     0,   2'b00, 0, 0,     0, 0,     0, 0,   0,     0,     8);

    reset = 1'b0; flush = 1'b0; issue_ready = 1'b1;
    idle_inputs();
    #1;
    chk("rst_free", 32'(free_count), 32'd8);
    chk("rst_valid", 32'(issue_valid), 32'd0);
    chk("rst_v1", issue_v1, 32'd0);
    chk("rst_dst", 32'(issue_dst), 32'd0);
    step(); step();
    reset = 1'b1;
    #1;
    chk("rst_dready", 32'(dispatch_ready), 32'd1);

    // vector table: inputs applied for one cycle, outputs checked after the edge
    for (int n = 0; n < NV; n++) begin
      idle_inputs();
      if (vecs[n].dv)
        set_disp(vecs[n].t1, vecs[n].r1, vecs[n].v1, vecs[n].t2, vecs[n].r2, vecs[n].v2, vecs[n].dst);
      cdb_valid = vecs[n].cv;
      cdb_tag   = {vecs[n].ct1, vecs[n].ct0};
      cdb_value = {vecs[n].cx1, vecs[n].cx0};
      step();
      chk($sformatf("vec%0d_free", n), 32'(free_count), 32'(vecs[n].efree));
      if (vecs[n].ev) chk_issue($sformatf("vec%0d", n), vecs[n].edst, vecs[n].ev1, vecs[n].ev2);
      else chk($sformatf("vec%0d_valid", n), 32'(issue_valid), 32'd0);
    end
    idle_inputs();

    // fill to full while the FU stalls
    issue_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      set_disp(0, 1, 32'(19 + k), 0, 1, 32'(2 * (19 + k)), 5'(19 + k));
      #1;
      chk($sformatf("fill%0d_dready", k), 32'(dispatch_ready), 32'd1);
      step();
      chk($sformatf("fill%0d_free", k), 32'(free_count), (k == 1) ? 32'd7 : 32'(9 - k));
    end
    set_disp(0, 1, 32'd99, 0, 1, 32'd99, 5'd31);
    #1;
    chk("full_dready", 32'(dispatch_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk_issue($sformatf("stall%0d", c), 5'd20, 32'd20, 32'd40);
      chk($sformatf("stall%0d_free", c), 32'(free_count), 32'd0);
    end
    idle_inputs();
    issue_ready = 1'b1;
    for (int n = 21; n <= 28; n++) begin
      step();
      chk_issue($sformatf("drain%0d", n), 5'(n), 32'(n), 32'(2 * n));
    end
    step();
    chk("drain_end_valid", 32'(issue_valid), 32'd0);
    chk("drain_end_free", 32'(free_count), 32'd8);

    // flush with 5 queued entries, a stalled issue slot and a concurrent dispatch
    issue_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      set_disp(0, 1, 32'(40 + k), 0, 1, 32'd1, 5'(40 + k));
      step();
    end
    chk("preflush_free", 32'(free_count), 32'd3);
    chk("preflush_valid", 32'(issue_valid), 32'd1);
    flush = 1'b1;
    set_disp(0, 1, 32'd46, 0, 1, 32'd1, 5'd46);
    #1;
    chk("flush_dready", 32'(dispatch_ready), 32'd0);
    step();
    chk("flush_free", 32'(free_count), 32'd8);
    chk("flush_valid", 32'(issue_valid), 32'd0);
    flush = 1'b0;
    idle_inputs();
    issue_ready = 1'b1;
    #1;
    chk("postflush_dready", 32'(dispatch_ready), 32'd1);
    step();
    chk("postflush_valid", 32'(issue_valid), 32'd0);
    chk("postflush_free", 32'(free_count), 32'd8);

    // asynchronous reset in the middle of traffic
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_disp(0, 1, 32'(50 + k), 0, 1, 32'd2, 5'(50 + k));
      step();
    end
    chk("prerst_free", 32'(free_count), 32'd6);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_free", 32'(free_count), 32'd8);
    chk("midrst_valid", 32'(issue_valid), 32'd0);
    chk("midrst_dst", 32'(issue_dst), 32'd0);
    chk("midrst_pc", issue_pc, 32'd0);
    idle_inputs();
    issue_ready = 1'b1;
    step();
    reset = 1'b1;
    set_disp(0, 1, 32'd5, 0, 1, 32'd6, 5'd21);
    step();
    idle_inputs();
    chk("afterrst_free", 32'(free_count), 32'd7);
    step();
    chk_issue("afterrst", 5'd21, 32'd5, 32'd6);
    step();
    chk("afterrst_idle", 32'(issue_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
